debug_pipeline_sequencer: RTL and testbench

Debug-unit controller that sequences the MIPS pipeline and reads back its state. It accepts byte commands from the UART receiver and drives the pipeline-wide enable for continuous run or single step. After every run or step, and on explicit request, it walks the register-file debug read port and streams a fixed frame (PC, 32 registers, cycle count) to the UART transmitter one byte at a time under a start/done handshake.

---
 rtl/debug_pipeline_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_debug_pipeline_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_pipeline_sequencer.sv
// Debug-unit sequencer: runs or single-steps the pipeline from UART commands and
// streams a PC / register file / cycle-count frame to the UART transmitter.
module debug_pipeline_sequencer #(
    parameter int CANT_REGISTROS      = 32,
    parameter int CANT_BITS_REGISTROS = 32,
    parameter int CANT_BITS_ADDR      = 11,
    parameter int CANT_BITS_CMD       = 8
) (
    input  logic                              i_clock,
    input  logic                              i_soft_reset,
    input  logic                              i_cmd_valid,
    input  logic [CANT_BITS_CMD-1:0]          i_cmd,
    input  logic                              i_halt_detected,
    input  logic [CANT_BITS_ADDR-1:0]         i_pc,
    output logic                              o_enable_pipeline,
    output logic [$clog2(CANT_REGISTROS)-1:0] o_reg_read_addr,
    input  logic [CANT_BITS_REGISTROS-1:0]    i_reg_data,
    output logic [7:0]                        o_tx_data,
    output logic                              o_tx_start,
    input  logic                              i_tx_done,
    output logic                              o_busy,
    output logic                              o_halted
);

    localparam int ADDR_W    = $clog2(CANT_REGISTROS);
    localparam int ITEM_W    = $clog2(CANT_REGISTROS + 2);
    localparam int SHIFT_W   = (CANT_BITS_REGISTROS > 32) ? CANT_BITS_REGISTROS : 32;
    localparam int BYTE_W    = $clog2(SHIFT_W / 8 + 1);
    localparam int PC_SHIFT  = SHIFT_W - 16;
    localparam int CNT_SHIFT = SHIFT_W - 32;
    localparam int REG_SHIFT = SHIFT_W - CANT_BITS_REGISTROS;

    localparam logic [ITEM_W-1:0] LAST_ITEM   = ITEM_W'(CANT_REGISTROS + 1);
    localparam logic [BYTE_W-1:0] PC_BYTES    = BYTE_W'(2);
    localparam logic [BYTE_W-1:0] CNT_BYTES   = BYTE_W'(4);
    localparam logic [BYTE_W-1:0] REG_BYTES_W = BYTE_W'(CANT_BITS_REGISTROS / 8);

    localparam logic [CANT_BITS_CMD-1:0] CMD_RUN  = CANT_BITS_CMD'(1);
    localparam logic [CANT_BITS_CMD-1:0] CMD_STEP = CANT_BITS_CMD'(2);
    localparam logic [CANT_BITS_CMD-1:0] CMD_DUMP = CANT_BITS_CMD'(3);
    localparam logic [CANT_BITS_CMD-1:0] CMD_STOP = CANT_BITS_CMD'(4);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP    = 3'd2,
        ST_LOAD    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    state_t              state_r;
    logic                enable_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          tx_data_r;
    logic                tx_start_r;
    logic                busy_r;
    logic                halted_r;
    logic [31:0]         cycle_cnt_r;
    logic [ITEM_W-1:0]   item_r;
    logic [BYTE_W-1:0]   bytes_left_r;
    logic [SHIFT_W-1:0]  shift_r;
    logic                load_phase_r;

    logic                cmd_run_s;
    logic                cmd_step_s;
    logic                cmd_dump_s;
    logic                cmd_stop_s;
    logic                is_reg_item_s;
    logic [15:0]         pc16_s;

    // Item 0 is the PC, items 1..CANT_REGISTROS are registers, the last is the counter.
    function automatic logic [BYTE_W-1:0] item_bytes(input logic [ITEM_W-1:0] item);
        if (item == ITEM_W'(0)) begin
            return PC_BYTES;
        end else if (item == LAST_ITEM) begin
            return CNT_BYTES;
        end else begin
            return REG_BYTES_W;
        end
    endfunction

    assign cmd_run_s     = i_cmd_valid && (i_cmd == CMD_RUN);
    assign cmd_step_s    = i_cmd_valid && (i_cmd == CMD_STEP);
    assign cmd_dump_s    = i_cmd_valid && (i_cmd == CMD_DUMP);
    assign cmd_stop_s    = i_cmd_valid && (i_cmd == CMD_STOP);
    assign is_reg_item_s = (item_r != ITEM_W'(0)) && (item_r != LAST_ITEM);
    assign pc16_s        = 16'(i_pc);

    // Control FSM: command decode, pipeline enable and byte-wise frame serialisation
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state_r      <= ST_IDLE;
            enable_r     <= 1'b0;
            addr_r       <= '0;
            tx_data_r    <= 8'h00;
            tx_start_r   <= 1'b0;
            busy_r       <= 1'b0;
            item_r       <= '0;
            bytes_left_r <= '0;
            shift_r      <= '0;
            load_phase_r <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_run_s && !halted_r) begin
                        state_r  <= ST_RUN;
                        enable_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else if (cmd_step_s && !halted_r) begin
                        state_r  <= ST_STEP;
                        enable_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else if (cmd_dump_s) begin
                        state_r      <= ST_LOAD;
                        busy_r       <= 1'b1;
                        item_r       <= '0;
                        load_phase_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Halt and STOP both end the run the same way; o_halted tracks halt separately.
                    if (i_halt_detected || cmd_stop_s) begin
                        state_r      <= ST_LOAD;
                        enable_r     <= 1'b0;
                        item_r       <= '0;
                        load_phase_r <= 1'b0;
                    end else begin
                        enable_r <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_r      <= ST_LOAD;
                    enable_r     <= 1'b0;
                    item_r       <= '0;
                    load_phase_r <= 1'b0;
                end
                ST_LOAD: begin
                    if (!load_phase_r) begin
                        load_phase_r <= 1'b1;
                        if (is_reg_item_s) begin
                            addr_r <= ADDR_W'(item_r - ITEM_W'(1));
                        end else if (item_r == ITEM_W'(0)) begin
                            shift_r <= SHIFT_W'(pc16_s) << PC_SHIFT;
                        end else begin
                            shift_r <= SHIFT_W'(cycle_cnt_r) << CNT_SHIFT;
                        end
                    end else begin
                        load_phase_r <= 1'b0;
                        bytes_left_r <= item_bytes(item_r);
                        state_r      <= ST_SEND;
                        if (is_reg_item_s) begin
                            shift_r <= SHIFT_W'(i_reg_data) << REG_SHIFT;
                        end else begin
                            shift_r <= shift_r;
                        end
                    end
                end
                ST_SEND: begin
                    tx_data_r  <= shift_r[SHIFT_W-1 -: 8];
                    tx_start_r <= 1'b1;
                    state_r    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (bytes_left_r > BYTE_W'(1)) begin
                            shift_r      <= shift_r << 4'd8;
                            bytes_left_r <= bytes_left_r - BYTE_W'(1);
                            state_r      <= ST_SEND;
                        end else if (item_r != LAST_ITEM) begin
                            item_r       <= item_r + ITEM_W'(1);
                            load_phase_r <= 1'b0;
                            state_r      <= ST_LOAD;
                        end else begin
                            item_r       <= '0;
                            bytes_left_r <= '0;
                            busy_r       <= 1'b0;
                            state_r      <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_WAIT_TX;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of enabled pipeline cycles
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            cycle_cnt_r <= 32'h0000_0000;
        end else if (enable_r && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    // Sticky halt flag, only a halt seen while the pipeline is enabled counts
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            halted_r <= 1'b0;
        end else if (enable_r && i_halt_detected) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    assign o_enable_pipeline = enable_r;
    assign o_reg_read_addr   = addr_r;
    assign o_tx_data         = tx_data_r;
    assign o_tx_start        = tx_start_r;
    assign o_busy            = busy_r;
    assign o_halted          = halted_r;

endmodule

// File: tb/tb_debug_pipeline_sequencer.sv
// Directed bench for debug_pipeline_sequencer: register file R[k]=k and a
// UART transmitter model that answers each start with a done after tx_delay cycles.
module tb_debug_pipeline_sequencer;

    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_DUMP = 8'h03;
    localparam logic [7:0] CMD_STOP = 8'h04;

    logic        clk = 1'b0;
    logic        soft_reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        halt = 1'b0;
    logic [10:0] pc = 11'h000;
    logic        enable;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic        halted;
    logic        tx_done_auto = 1'b0;
    logic        tx_done_spur = 1'b0;
    logic        tx_done_force = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_count = 0;
    int last_en_cyc = 0;
    int overlap_cnt = 0;
    int done_cnt = 0;
    int tx_delay = 2;
    bit spur_en = 1'b0;
    logic [7:0] bytes_q[$];
    int         start_cyc_q[$];
    logic [7:0] exp_q[$];

    assign tx_done  = tx_done_auto | tx_done_spur | tx_done_force;
    assign reg_data = 32'(reg_addr);

    always #5 clk = ~clk;

    debug_pipeline_sequencer dut (
        .i_clock          (clk),
        .i_soft_reset     (soft_reset),
        .i_cmd_valid      (cmd_valid),
        .i_cmd            (cmd),
        .i_halt_detected  (halt),
        .i_pc             (pc),
        .o_enable_pipeline(enable),
        .o_reg_read_addr  (reg_addr),
        .i_reg_data       (reg_data),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .i_tx_done        (tx_done),
        .o_busy           (busy),
        .o_halted         (halted)
    );

    // Transmitter model and activity monitor, sampling on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            tx_done_spur = tx_done_auto & spur_en;
            tx_done_auto = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done_auto = 1'b1;
            end
            if (enable === 1'b1) begin
                en_count++;
                last_en_cyc = cyc;
            end
            if (tx_start === 1'b1) begin
                if (done_cnt != 0) overlap_cnt++;
                bytes_q.push_back(tx_data);
                start_cyc_q.push_back(cyc);
                done_cnt = tx_delay - 1;
            end
        end
    end

    task automatic build_expected(input logic [10:0] pc_v, input logic [31:0] cnt_v);
        logic [15:0] pc16;
        pc16 = {5'b00000, pc_v};
        exp_q.delete();
        exp_q.push_back(pc16[15:8]);
        exp_q.push_back(pc16[7:0]);
        for (int r = 0; r < 32; r++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'(r));
        end
        exp_q.push_back(cnt_v[31:24]);
        exp_q.push_back(cnt_v[23:16]);
        exp_q.push_back(cnt_v[15:8]);
        exp_q.push_back(cnt_v[7:0]);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = 8'h00;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        soft_reset = 1'b1;
        cmd_valid = 1'b0;
        halt = 1'b0;
        repeat (2) @(negedge clk);
        soft_reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int base_b;
        int base_en;
        do_reset();
        base_en = en_count;
        base_b = bytes_q.size();
        repeat (10) @(negedge clk);
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable: got %b expected 0", enable); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (reg_addr !== 5'd0) begin failures++; $display("FAIL reset_reg_addr: got %0d expected 0", reg_addr); end
        checks++; if (en_count - base_en != 0) begin failures++; $display("FAIL reset_idle_enable: got %0d cycles expected 0", en_count - base_en); end
        @(negedge clk);
        tx_done_force = 1'b1;
        @(negedge clk);
        tx_done_force = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_txdone_busy: got %b expected 0", busy); end
        checks++; if (bytes_q.size() - base_b != 0) begin failures++; $display("FAIL idle_txdone_starts: got %0d expected 0", bytes_q.size() - base_b); end
    endtask

    task automatic test_step();
        int base_b;
        int base_en;
        int errs;
        bit ok;
        do_reset();
        pc = 11'h5A3;
        tx_delay = 2;
        base_b = bytes_q.size();
        base_en = en_count;
        build_expected(11'h5A3, 32'd1);
        send_cmd(CMD_STEP);
        wait_idle(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL step_timeout: busy still %b expected 0", busy); end
        checks++; if (en_count - base_en != 1) begin failures++; $display("FAIL step_enable_cycles: got %0d expected 1", en_count - base_en); end
        checks++; if (bytes_q.size() - base_b != 134) begin failures++; $display("FAIL step_byte_count: got %0d expected 134", bytes_q.size() - base_b); end
        if (bytes_q.size() - base_b >= 7) begin
            checks++; if (start_cyc_q[base_b] - last_en_cyc != 4) begin failures++; $display("FAIL step_first_start: got %0d expected 4", start_cyc_q[base_b] - last_en_cyc); end
            checks++; if (start_cyc_q[base_b + 3] - start_cyc_q[base_b + 2] != 3) begin failures++; $display("FAIL step_spacing_in_item: got %0d expected 3", start_cyc_q[base_b + 3] - start_cyc_q[base_b + 2]); end
            checks++; if (start_cyc_q[base_b + 6] - start_cyc_q[base_b + 5] != 5) begin failures++; $display("FAIL step_spacing_items: got %0d expected 5", start_cyc_q[base_b + 6] - start_cyc_q[base_b + 5]); end
        end else begin
            checks++; failures++;
            $display("FAIL step_timing: got %0d bytes expected at least 7", bytes_q.size() - base_b);
        end
        errs = 0;
        for (int i = 0; i < 134; i++) begin
            if (base_b + i >= bytes_q.size()) errs++;
            else if (bytes_q[base_b + i] !== exp_q[i]) errs++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL step_frame: bytes_wrong=%0d expected 0", errs); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL step_halted: got %b expected 0", halted); end
    endtask

    task automatic test_run_halt();
        int base_b;
        int base_en;
        int errs;
        bit ok;
        do_reset();
        pc = 11'h123;
        tx_delay = 2;
        base_b = bytes_q.size();
        base_en = en_count;
        build_expected(11'h123, 32'd10);
        send_cmd(CMD_RUN);
        repeat (9) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        wait_idle(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL halt_timeout: busy still %b expected 0", busy); end
        checks++; if (en_count - base_en != 10) begin failures++; $display("FAIL halt_enable_cycles: got %0d expected 10", en_count - base_en); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b expected 1", halted); end
        errs = 0;
        for (int i = 0; i < 134; i++) begin
            if (base_b + i >= bytes_q.size()) errs++;
            else if (bytes_q[base_b + i] !== exp_q[i]) errs++;
        end
        checks++; if (errs != 0 || bytes_q.size() - base_b != 134) begin failures++; $display("FAIL halt_frame: bytes_wrong=%0d count=%0d expected 0 and 134", errs, bytes_q.size() - base_b); end
        base_en = en_count;
        send_cmd(CMD_RUN);
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || en_count != base_en) begin failures++; $display("FAIL halted_run_ignored: busy=%b enables=%0d expected 0 and 0", busy, en_count - base_en); end
        send_cmd(CMD_STEP);
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || en_count != base_en) begin failures++; $display("FAIL halted_step_ignored: busy=%b enables=%0d expected 0 and 0", busy, en_count - base_en); end
        base_b = bytes_q.size();
        send_cmd(CMD_DUMP);
        wait_idle(2000, ok);
        errs = 0;
        for (int i = 0; i < 134; i++) begin
            if (base_b + i >= bytes_q.size()) errs++;
            else if (bytes_q[base_b + i] !== exp_q[i]) errs++;
        end
        checks++; if (!ok || errs != 0 || bytes_q.size() - base_b != 134) begin failures++; $display("FAIL halted_dump_frame: done=%b bytes_wrong=%0d count=%0d expected 1, 0, 134", ok, errs, bytes_q.size() - base_b); end
        checks++; if (en_count != base_en) begin failures++; $display("FAIL halted_dump_enable: got %0d expected 0", en_count - base_en); end
    endtask

    task automatic test_run_stop();
        int base_b;
        int base_en;
        int errs;
        bit ok;
        do_reset();
        pc = 11'h042;
        tx_delay = 2;
        base_b = bytes_q.size();
        base_en = en_count;
        build_expected(11'h042, 32'd5);
        send_cmd(CMD_RUN);
        repeat (3) @(negedge clk);
        send_cmd(CMD_STOP);
        repeat (20) @(negedge clk);
        send_cmd(CMD_STEP);
        wait_idle(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stop_timeout: busy still %b expected 0", busy); end
        checks++; if (en_count - base_en != 5) begin failures++; $display("FAIL stop_enable_cycles: got %0d expected 5", en_count - base_en); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL stop_halted: got %b expected 0", halted); end
        errs = 0;
        for (int i = 0; i < 134; i++) begin
            if (base_b + i >= bytes_q.size()) errs++;
            else if (bytes_q[base_b + i] !== exp_q[i]) errs++;
        end
        checks++; if (errs != 0 || bytes_q.size() - base_b != 134) begin failures++; $display("FAIL stop_frame: bytes_wrong=%0d count=%0d expected 0 and 134", errs, bytes_q.size() - base_b); end
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0 || en_count - base_en != 5) begin failures++; $display("FAIL stop_step_dropped: busy=%b enables=%0d expected 0 and 5", busy, en_count - base_en); end
    endtask

    task automatic test_slow_dump();
        int base_b;
        int base_en;
        int base_ov;
        int errs;
        bit ok;
        do_reset();
        pc = 11'h7FF;
        tx_delay = 100;
        spur_en = 1'b1;
        base_b = bytes_q.size();
        base_en = en_count;
        base_ov = overlap_cnt;
        build_expected(11'h7FF, 32'd0);
        send_cmd(CMD_DUMP);
        wait_idle(20000, ok);
        spur_en = 1'b0;
        tx_delay = 2;
        checks++; if (!ok) begin failures++; $display("FAIL slow_timeout: busy still %b expected 0", busy); end
        checks++; if (en_count - base_en != 0) begin failures++; $display("FAIL slow_enable: got %0d expected 0", en_count - base_en); end
        checks++; if (overlap_cnt - base_ov != 0) begin failures++; $display("FAIL slow_overlap: got %0d expected 0", overlap_cnt - base_ov); end
        errs = 0;
        for (int i = 0; i < 134; i++) begin
            if (base_b + i >= bytes_q.size()) errs++;
            else if (bytes_q[base_b + i] !== exp_q[i]) errs++;
        end
        checks++; if (errs != 0 || bytes_q.size() - base_b != 134) begin failures++; $display("FAIL slow_frame: bytes_wrong=%0d count=%0d expected 0 and 134", errs, bytes_q.size() - base_b); end
    endtask

    task automatic test_reset_mid_frame();
        int base_b;
        int errs;
        bit ok;
        do_reset();
        pc = 11'h3C5;
        tx_delay = 2;
        base_b = bytes_q.size();
        send_cmd(CMD_DUMP);
        for (int i = 0; i < 1000 && (bytes_q.size() - base_b < 40); i++) @(negedge clk);
        checks++; if (bytes_q.size() - base_b != 40) begin failures++; $display("FAIL midreset_reach40: got %0d bytes expected 40", bytes_q.size() - base_b); end
        soft_reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL midreset_start: got %b expected 0", tx_start); end
        soft_reset = 1'b0;
        base_b = bytes_q.size();
        repeat (20) @(negedge clk);
        checks++; if (bytes_q.size() - base_b != 0) begin failures++; $display("FAIL midreset_no_more: got %0d bytes expected 0", bytes_q.size() - base_b); end
        build_expected(11'h3C5, 32'd0);
        send_cmd(CMD_DUMP);
        wait_idle(2000, ok);
        errs = 0;
        for (int i = 0; i < 134; i++) begin
            if (base_b + i >= bytes_q.size()) errs++;
            else if (bytes_q[base_b + i] !== exp_q[i]) errs++;
        end
        checks++; if (!ok || errs != 0 || bytes_q.size() - base_b != 134) begin failures++; $display("FAIL midreset_dump_frame: done=%b bytes_wrong=%0d count=%0d expected 1, 0, 134", ok, errs, bytes_q.size() - base_b); end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_step();
        test_run_halt();
        test_run_stop();
        test_slow_dump();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
